duart_access_sequencer: RTL and testbench

- Sits between the CPU bus and the d2681 DUART register port and is the sole driver of that port (enable/we/addr/di).
- Arbitrates CPU register accesses against an autonomous channel-A engine.
- The engine drains a TX byte FIFO into the transmit register (addr 3 write) and moves received bytes (addr 3 read) into a one-entry holding slot.
- Every engine data transfer is gated by a status poll (addr 1 read).

---
 rtl/duart_access_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_duart_access_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/duart_access_sequencer.sv
// Sole owner of the d2681 register port: arbitrates CPU accesses against a
// channel-A engine that polls status, drains a TX FIFO and fills an RX slot.
module duart_access_sequencer #(
    parameter int TX_DEPTH = 16,
    parameter int POLL_GAP = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clken,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [3:0] cpu_addr,
    input  logic [7:0] cpu_di,
    output logic [7:0] cpu_do,
    output logic       cpu_ack,
    input  logic       tx_wr,
    input  logic [7:0] tx_data,
    output logic       tx_full,
    output logic       tx_drop,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       d_enable,
    output logic       d_we,
    output logic [3:0] d_addr,
    output logic [7:0] d_di,
    input  logic [7:0] d_do
);
    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = $clog2(POLL_GAP + 1);

    localparam logic [3:0] ADDR_STATUS = 4'd1;
    localparam logic [3:0] ADDR_DATA   = 4'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CPU,
        S_POLL,
        S_RX,
        S_TX
    } state_t;

    state_t           state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             d_enable_q, d_enable_d;
    logic             d_we_q, d_we_d;
    logic [3:0]       d_addr_q, d_addr_d;
    logic [7:0]       d_di_q, d_di_d;
    logic             cpu_ack_q, cpu_ack_d;
    logic [7:0]       cpu_do_q, cpu_do_d;
    logic             rx_valid_q, rx_valid_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic [7:0]       fifo_q [TX_DEPTH];
    logic [7:0]       fifo_d [TX_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tx_full_q, tx_full_d;
    logic             tx_drop_q, tx_drop_d;

    logic done;
    logic push;
    logic pop;
    logic fill;

    // Sequencer: an access completes on the first clken edge while d_enable is up.
    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        d_enable_d = d_enable_q;
        d_we_d     = d_we_q;
        d_addr_d   = d_addr_q;
        d_di_d     = d_di_q;
        cpu_ack_d  = 1'b0;
        cpu_do_d   = cpu_do_q;
        pop        = 1'b0;
        fill       = 1'b0;
        done       = d_enable_q && clken;

        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    state_d    = S_CPU;
                    d_enable_d = 1'b1;
                    d_we_d     = cpu_we;
                    d_addr_d   = cpu_addr;
                    d_di_d     = cpu_di;
                end else if (gap_q == '0) begin
                    state_d    = S_POLL;
                    d_enable_d = 1'b1;
                    d_we_d     = 1'b0;
                    d_addr_d   = ADDR_STATUS;
                    d_di_d     = 8'h00;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            S_CPU: begin
                if (done) begin
                    state_d    = S_IDLE;
                    d_enable_d = 1'b0;
                    cpu_ack_d  = 1'b1;
                    cpu_do_d   = d_we_q ? 8'h00 : d_do;
                end
            end
            S_POLL: begin
                // The data access follows the poll directly, so no CPU access can slip in between.
                if (done) begin
                    if (d_do[0] && !rx_valid_q) begin
                        state_d  = S_RX;
                        d_we_d   = 1'b0;
                        d_addr_d = ADDR_DATA;
                        d_di_d   = 8'h00;
                    end else if (d_do[2] && (count_q != '0)) begin
                        state_d  = S_TX;
                        d_we_d   = 1'b1;
                        d_addr_d = ADDR_DATA;
                        d_di_d   = fifo_q[rd_ptr_q];
                    end else begin
                        state_d    = S_IDLE;
                        d_enable_d = 1'b0;
                        gap_d      = GAP_W'(POLL_GAP);
                    end
                end
            end
            S_RX: begin
                if (done) begin
                    fill       = 1'b1;
                    state_d    = S_IDLE;
                    d_enable_d = 1'b0;
                    gap_d      = GAP_W'(POLL_GAP);
                end
            end
            S_TX: begin
                if (done) begin
                    pop        = 1'b1;
                    state_d    = S_IDLE;
                    d_enable_d = 1'b0;
                    gap_d      = GAP_W'(POLL_GAP);
                end
            end
            default: begin
                state_d    = S_IDLE;
                d_enable_d = 1'b0;
            end
        endcase
    end

    // TX FIFO and RX holding slot
    always_comb begin
        push      = tx_wr && !tx_full_q;
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        tx_drop_d = tx_wr && tx_full_q;

        if (push) begin
            fifo_d[wr_ptr_q] = tx_data;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        tx_full_d = (count_d == CNT_W'(TX_DEPTH));

        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (fill) begin
            rx_valid_d = 1'b1;
            rx_data_d  = d_do;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            gap_q      <= '0;
            d_enable_q <= 1'b0;
            d_we_q     <= 1'b0;
            d_addr_q   <= '0;
            d_di_q     <= '0;
            cpu_ack_q  <= 1'b0;
            cpu_do_q   <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            tx_full_q  <= 1'b0;
            tx_drop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            d_enable_q <= d_enable_d;
            d_we_q     <= d_we_d;
            d_addr_q   <= d_addr_d;
            d_di_q     <= d_di_d;
            cpu_ack_q  <= cpu_ack_d;
            cpu_do_q   <= cpu_do_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            tx_full_q  <= tx_full_d;
            tx_drop_q  <= tx_drop_d;
        end
    end

    // FIFO storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign cpu_do   = cpu_do_q;
    assign cpu_ack  = cpu_ack_q;
    assign tx_full  = tx_full_q;
    assign tx_drop  = tx_drop_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign d_enable = d_enable_q;
    assign d_we     = d_we_q;
    assign d_addr   = d_addr_q;
    assign d_di     = d_di_q;

endmodule

// File: tb/tb_duart_access_sequencer.sv
// Directed bench for duart_access_sequencer with a behavioural DUART register model.
module tb_duart_access_sequencer;
    localparam int TX_DEPTH = 16;
    localparam int POLL_GAP = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       clken;
    logic       cpu_req;
    logic       cpu_we;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_di;
    logic [7:0] cpu_do;
    logic       cpu_ack;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic       tx_full;
    logic       tx_drop;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       d_enable;
    logic       d_we;
    logic [3:0] d_addr;
    logic [7:0] d_di;
    logic [7:0] d_do;

    logic [7:0] status_reg;
    logic [7:0] rx_buf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_cnt = 0;
    logic [12:0] log_q [$];
    int          log_cyc [$];

    logic slow;
    int   ph;

    always #5 clk = ~clk;

    duart_access_sequencer #(
        .TX_DEPTH(TX_DEPTH),
        .POLL_GAP(POLL_GAP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .clken    (clken),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_di   (cpu_di),
        .cpu_do   (cpu_do),
        .cpu_ack  (cpu_ack),
        .tx_wr    (tx_wr),
        .tx_data  (tx_data),
        .tx_full  (tx_full),
        .tx_drop  (tx_drop),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .d_enable (d_enable),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_di     (d_di),
        .d_do     (d_do)
    );

    // DUART register read port: combinational from the address
    assign d_do = (d_addr == 4'd1) ? status_reg :
                  (d_addr == 4'd3) ? rx_buf : 8'h00;

    // Every access the DUART sees: {we, addr, di} plus the cycle it completed in
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clken && d_enable) begin
            log_q.push_back({d_we, d_addr, d_di});
            log_cyc.push_back(cyc);
        end
        if (cpu_ack) ack_cnt <= ack_cnt + 1;
    end

    task automatic tick();
        @(negedge clk);
        if (slow) begin
            ph    = (ph == 2) ? 0 : ph + 1;
            clken = (ph == 0);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        tx_wr   = 1'b1;
        tx_data = b;
        tick();
        tx_wr   = 1'b0;
    endtask

    initial begin
        int base;
        int ack0;
        int n;
        int wn;

        reset = 1'b1; clken = 1'b1; slow = 1'b0; ph = 0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 4'd0; cpu_di = 8'h00;
        tx_wr = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
        status_reg = 8'h00; rx_buf = 8'h00;
        ticks(3);

        chk("reset_port", {d_enable, d_we, d_addr, d_di}, 32'h0);
        chk("reset_cpu", {cpu_ack, cpu_do}, 32'h0);
        chk("reset_fifo", {tx_full, tx_drop}, 32'h0);
        chk("reset_rx", {rx_valid, rx_data}, 32'h0);
        reset = 1'b0;

        // Idle polling with status 0x00
        base = log_q.size();
        ack0 = ack_cnt;
        ticks(40);
        chk("idle_poll_count", log_q.size() - base, 7);
        for (int i = base; i < log_q.size(); i++) begin
            chk("idle_poll_access", {27'd0, log_q[i][12:8]}, 32'h01);
            if (i > base) chk("idle_poll_interval", log_cyc[i] - log_cyc[i-1], POLL_GAP + 2);
        end
        chk("idle_rx_valid", rx_valid, 1'b0);
        chk("idle_no_ack", ack_cnt - ack0, 0);

        // Two TX bytes with status 0x0C
        status_reg = 8'h0C;
        base = log_q.size();
        push_byte(8'h41);
        push_byte(8'h42);
        ticks(40);
        status_reg = 8'h00;
        wn = 0;
        for (int i = base; i < log_q.size(); i++) begin
            if (log_q[i][12]) begin
                chk("tx_write_addr", {28'd0, log_q[i][11:8]}, 32'd3);
                chk("tx_write_data", {24'd0, log_q[i][7:0]}, (wn == 0) ? 32'h41 : 32'h42);
                chk("tx_prev_poll", {27'd0, log_q[i-1][12:8]}, 32'h01);
                wn++;
            end
        end
        chk("tx_write_count", wn, 2);
        chk("tx_not_full", tx_full, 1'b0);

        // RX into the holding slot, blocked while full
        status_reg = 8'h01;
        rx_buf     = 8'h5A;
        base = log_q.size();
        ticks(40);
        n = 0;
        for (int i = base; i < log_q.size(); i++) if (log_q[i][12:8] == 5'h03) n++;
        chk("rx_read_once", n, 1);
        chk("rx_valid_set", rx_valid, 1'b1);
        chk("rx_data_5a", rx_data, 8'h5A);
        rx_buf   = 8'h33;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("rx_popped", rx_valid, 1'b0);
        ticks(20);
        n = 0;
        for (int i = base; i < log_q.size(); i++) if (log_q[i][12:8] == 5'h03) n++;
        chk("rx_read_resumed", n, 2);
        chk("rx_valid_again", rx_valid, 1'b1);
        chk("rx_data_33", rx_data, 8'h33);
        status_reg = 8'h00;
        rx_ready   = 1'b1;
        tick();
        rx_ready   = 1'b0;

        // CPU read of the data register
        rx_buf   = 8'hA5;
        cpu_req  = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd3; cpu_di = 8'h00;
        n = 0;
        while (cpu_ack !== 1'b1 && n < 30) begin tick(); n++; end
        chk("cpu_rd_ack_seen", cpu_ack, 1'b1);
        chk("cpu_rd_data", cpu_do, 8'hA5);
        cpu_req = 1'b0;
        ticks(3);

        // CPU write arriving during a poll that leads to TX
        push_byte(8'h77);
        n = 0;
        while (!(d_enable && !d_we && d_addr == 4'd1) && n < 30) begin tick(); n++; end
        chk("wait_poll", {d_enable, d_we, d_addr}, 6'b10_0001);
        base = log_q.size();
        ack0 = ack_cnt;
        status_reg = 8'h04;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd5; cpu_di = 8'h08;
        n = 0;
        while (cpu_ack !== 1'b1 && n < 30) begin tick(); n++; end
        chk("cpu_wr_ack_seen", cpu_ack, 1'b1);
        chk("cpu_wr_do_zero", cpu_do, 8'h00);
        cpu_req = 1'b0;
        ticks(5);
        status_reg = 8'h00;
        chk("cpu_wr_ack_once", ack_cnt - ack0, 1);
        chk("lock_seq_len_ok", (log_q.size() - base) >= 3, 1'b1);
        if (log_q.size() - base >= 3) begin
            chk("lock_poll", {19'd0, log_q[base]}, 32'h0100);
            chk("lock_tx", {19'd0, log_q[base+1]}, 32'h1377);
            chk("lock_cpu", {19'd0, log_q[base+2]}, 32'h1508);
        end

        // Fill the FIFO and overflow it
        for (int i = 0; i < 17; i++) begin
            push_byte(8'h10 + 8'(i));
            if (i == 14) chk("fifo_not_full_15", tx_full, 1'b0);
            if (i == 15) chk("fifo_full_16", tx_full, 1'b1);
            if (i == 15) chk("fifo_no_drop_16", tx_drop, 1'b0);
            if (i == 16) chk("fifo_drop_17", tx_drop, 1'b1);
        end
        tick();
        chk("fifo_drop_pulse", tx_drop, 1'b0);
        chk("fifo_still_full", tx_full, 1'b1);
        base = log_q.size();
        status_reg = 8'h04;
        ticks(200);
        status_reg = 8'h00;
        wn = 0;
        for (int i = base; i < log_q.size(); i++) begin
            if (log_q[i][12]) begin
                chk("drain_data", {24'd0, log_q[i][7:0]}, 32'h10 + wn);
                wn++;
            end
        end
        chk("drain_count", wn, 16);
        chk("drain_not_full", tx_full, 1'b0);

        // Slow clken, reset while TX is pending
        push_byte(8'h99);
        slow = 1'b1;
        ph   = 0;
        status_reg = 8'h04;
        base = log_q.size();
        n = 0;
        while (!(d_enable && d_we && d_addr == 4'd3) && n < 60) begin tick(); n++; end
        chk("slow_in_tx", {d_enable, d_we, d_addr}, 6'b11_0011);
        reset = 1'b1;
        clken = 1'b0;
        tick();
        chk("abort_enable_low", d_enable, 1'b0);
        chk("abort_not_full", tx_full, 1'b0);
        reset = 1'b0;
        ticks(30);
        wn = 0;
        for (int i = base; i < log_q.size(); i++) if (log_q[i][12]) wn++;
        chk("abort_no_write", wn, 0);
        slow  = 1'b0;
        clken = 1'b1;
        ticks(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
